// File: rtl/time_keeper.sv
// Time-of-day and alarm register block: seconds/minutes/hours/day counters plus alarm setpoints, all registered.
// Advance inputs act on the next edge. Optional midnight pulse output is enabled by TIME_KEEPER_MIDNIGHT_PULSE_EN.
module time_keeper #(
  parameter int DIV = 1
) (
  input  logic       Pulse,
  input  logic       Reset,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] tday,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic [6:0] aday
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
  ,
  output logic       midnight
`endif
);

  localparam logic [15:0] TERM = 16'(DIV - 1);

  logic [15:0] presc;
  logic        tick;

  // >= rather than == so a corrupted value still wraps to 0 on its next increment
  function automatic logic [6:0] inc(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim) ? 7'd0 : v + 7'd1;
  endfunction

  assign tick = (presc >= TERM);

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      presc <= '0;
      tsec  <= '0;
      tmin  <= '0;
      thrs  <= '0;
      tday  <= '0;
      amin  <= '0;
      ahrs  <= '0;
      aday  <= 7'd7;
    end else if (Timeset) begin
      presc <= '0;
      tsec  <= '0;
      if (Minadv) tmin <= inc(tmin, 7'd59);
      if (Hrsadv) thrs <= inc(thrs, 7'd23);
      if (Dayadv) tday <= inc(tday, 7'd6);
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) begin
        tsec <= inc(tsec, 7'd59);
        if (tsec >= 7'd59) begin
          tmin <= inc(tmin, 7'd59);
          if (tmin >= 7'd59) begin
            thrs <= inc(thrs, 7'd23);
            if (thrs >= 7'd23) tday <= inc(tday, 7'd6);
          end
        end
      end
      // Time keeps running while the alarm is being set
      if (Alarmset) begin
        if (Minadv) amin <= inc(amin, 7'd59);
        if (Hrsadv) ahrs <= inc(ahrs, 7'd23);
        if (Dayadv) aday <= inc(aday, 7'd7);
      end
    end
  end

`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
  always_ff @(posedge Pulse) begin
    if (Reset) begin
      midnight <= 1'b0;
    end else begin
      midnight <= !Timeset && tick && (tsec >= 7'd59) && (tmin >= 7'd59) && (thrs >= 7'd23);
    end
  end
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: one instance at DIV=1 for counting/set modes, one at DIV=4 for the prescaler.
module tb_time_keeper;

  logic Pulse = 1'b0;
  logic Reset, Timeset, Alarmset, Minadv, Hrsadv, Dayadv;
  logic [6:0] tsec, tmin, thrs, tday, amin, ahrs, aday;
  logic Reset4, Timeset4;
  logic [6:0] tsec4, tmin4, thrs4, tday4, amin4, ahrs4, aday4;
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
  logic midnight, midnight4;
  logic seen_mid;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Pulse = ~Pulse;

  time_keeper #(.DIV(1)) dut (
    .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
    .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday),
    .amin(amin), .ahrs(ahrs), .aday(aday)
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    , .midnight(midnight)
`endif
  );

  time_keeper #(.DIV(4)) dut4 (
    .Pulse(Pulse), .Reset(Reset4), .Timeset(Timeset4), .Alarmset(1'b0),
    .Minadv(1'b0), .Hrsadv(1'b0), .Dayadv(1'b0),
    .tsec(tsec4), .tmin(tmin4), .thrs(thrs4), .tday(tday4),
    .amin(amin4), .ahrs(ahrs4), .aday(aday4)
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    , .midnight(midnight4)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge Pulse);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Timeset = 1'b1; Alarmset = 1'b0;
    Minadv = 1'b1; Hrsadv = 1'b0; Dayadv = 1'b0;
    Reset4 = 1'b1; Timeset4 = 1'b0;
    step(2);
    chk("rst_tsec", tsec, 0);
    chk("rst_tmin", tmin, 0);
    chk("rst_thrs", thrs, 0);
    chk("rst_tday", tday, 0);
    chk("rst_amin", amin, 0);
    chk("rst_ahrs", ahrs, 0);
    chk("rst_aday", aday, 7);
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    chk("rst_midnight", midnight, 0);
`endif

    Reset = 1'b0; Timeset = 1'b0; Minadv = 1'b0;
    step(1);
    chk("first_tick_tsec", tsec, 1);

    // Set Sat 23:59 via Timeset: all three advances for 6, then min+hrs for 17, then min for 36
    Timeset = 1'b1; Minadv = 1'b1; Hrsadv = 1'b1; Dayadv = 1'b1;
    step(6);
    Dayadv = 1'b0;
    step(17);
    Hrsadv = 1'b0;
    step(36);
    chk("set_tday6", tday, 6);
    chk("set_thrs23", thrs, 23);
    chk("set_tmin59", tmin, 59);
    chk("set_tsec0", tsec, 0);

    Timeset = 1'b0; Minadv = 1'b0;
    step(59);
    chk("pre_wrap_tsec", tsec, 59);
    chk("pre_wrap_thrs", thrs, 23);
    step(1);
    chk("wrap_tsec", tsec, 0);
    chk("wrap_tmin", tmin, 0);
    chk("wrap_thrs", thrs, 0);
    chk("wrap_tday", tday, 0);
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    chk("midnight_hi", midnight, 1);
`endif
    step(1);
    chk("post_wrap_tsec", tsec, 1);
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    chk("midnight_lo", midnight, 0);
`endif

    // Set-mode wraps must not carry
    Timeset = 1'b1; Minadv = 1'b1;
    step(61);
    chk("min_wrap_tmin", tmin, 1);
    chk("min_wrap_thrs", thrs, 0);
    chk("min_wrap_tsec", tsec, 0);
    Minadv = 1'b0; Hrsadv = 1'b1;
    step(5);
    chk("hrs_start", thrs, 5);
`ifdef TIME_KEEPER_MIDNIGHT_PULSE_EN
    seen_mid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      seen_mid = seen_mid | midnight;
    end
    chk("no_midnight_in_set", seen_mid, 0);
`else
    step(24);
`endif
    chk("hrs_wrap_thrs", thrs, 5);
    chk("hrs_wrap_tday", tday, 0);
    chk("hrs_wrap_tmin", tmin, 1);

    // Alarm day range 0..7 while time runs
    Timeset = 1'b0; Hrsadv = 1'b0; Alarmset = 1'b1; Dayadv = 1'b1;
    step(1);
    chk("aday_7_to_0", aday, 0);
    step(8);
    chk("aday_full_cycle", aday, 0);
    chk("alarm_mode_tsec", tsec, 9);
    chk("alarm_mode_thrs", thrs, 5);
    Dayadv = 1'b0; Minadv = 1'b1; Hrsadv = 1'b1;
    step(3);
    chk("amin_adv", amin, 3);
    chk("ahrs_adv", ahrs, 3);
    chk("alarm_tmin_hold", tmin, 1);
    chk("alarm_tsec_run", tsec, 12);

    // Timeset outranks Alarmset
    Timeset = 1'b1; Hrsadv = 1'b0;
    step(5);
    chk("prio_tmin", tmin, 6);
    chk("prio_amin", amin, 3);
    chk("prio_tsec", tsec, 0);

    // RUN ignores advance inputs
    Timeset = 1'b0; Alarmset = 1'b0;
    step(2);
    chk("run_ign_tmin", tmin, 6);
    chk("run_ign_amin", amin, 3);
    chk("run_tsec", tsec, 2);
    Minadv = 1'b0;

    // Prescaler, DIV=4
    step(1);
    Reset4 = 1'b0;
    step(3);
    chk("div4_c3", tsec4, 0);
    step(1);
    chk("div4_c4", tsec4, 1);
    step(3);
    chk("div4_c7", tsec4, 1);
    step(1);
    chk("div4_c8", tsec4, 2);
    step(4);
    chk("div4_c12", tsec4, 3);

    Reset4 = 1'b1;
    step(1);
    chk("div4_rst_aday", aday4, 7);
    Reset4 = 1'b0;
    step(5);
    chk("div4_c5", tsec4, 1);
    Timeset4 = 1'b1;
    step(1);
    chk("div4_ts_clear", tsec4, 0);
    Timeset4 = 1'b0;
    step(3);
    chk("div4_after_ts3", tsec4, 0);
    step(1);
    chk("div4_after_ts4", tsec4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
